// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control constants: FSM state encoding, PC source select
// codes, exception handler address and a saturating counter helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } pipe_state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_EXC = 2'b01;
    localparam logic [1:0] PC_SEL_EPC = 2'b10;

    localparam logic [31:0] EXC_HANDLER_ADDR = 32'h0000_4180;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// HI/LO multiply/divide busy counter: loads the operation latency on start,
// then counts down to zero; busy while the count is nonzero.
module md_busy_cnt #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    localparam int CW = $clog2(DIV_CYC + 1);

    logic [CW-1:0] count;

    // A load while already counting simply restarts the latency window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: interlock stalls, exception/eret flushes,
// stage-register enable/clear decode and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_stall_req,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use_d,
    input  logic        exc_req,
    input  logic        eret_req,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        en_fd,
    output logic        en_de,
    output logic        en_em,
    output logic        en_mw,
    output logic        clr_fd,
    output logic        clr_de,
    output logic        clr_em,
    output logic        clr_mw,
    output logic        md_busy,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt
);

    pipe_state_t state_q;
    pipe_state_t state_next;
    logic        cnt_busy;
    logic        stall_now;
    logic        md_load;

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load),
        .is_div (md_is_div),
        .busy   (cnt_busy)
    );

    // Only a HI/LO op that actually advances into E (not squashed) starts the unit.
    assign md_load = md_start && en_em && !exc_req && !eret_req;
    assign md_busy = cnt_busy;
    assign state   = state_q;

    // The instruction in D during FLUSH is already squashed, so interlocks are ignored.
    assign stall_now = (state_q != ST_FLUSH) &&
                       (d_stall_req || (md_use_d && (cnt_busy || md_start)));

    always_comb begin
        pc_en      = 1'b1;
        pc_sel     = PC_SEL_SEQ;
        en_fd      = 1'b1;
        en_de      = 1'b1;
        en_em      = 1'b1;
        en_mw      = 1'b1;
        clr_fd     = 1'b0;
        clr_de     = 1'b0;
        clr_em     = 1'b0;
        clr_mw     = 1'b0;
        state_next = ST_RUN;

        if (exc_req) begin
            pc_sel     = PC_SEL_EXC;
            clr_fd     = 1'b1;
            clr_de     = 1'b1;
            clr_em     = 1'b1;
            clr_mw     = 1'b1;
            state_next = ST_FLUSH;
        end else if (eret_req) begin
            pc_sel     = PC_SEL_EPC;
            clr_fd     = 1'b1;
            clr_de     = 1'b1;
            clr_em     = 1'b1;
            state_next = ST_FLUSH;
        end else if (stall_now) begin
            pc_en      = 1'b0;
            en_fd      = 1'b0;
            clr_de     = 1'b1;
            state_next = ST_STALL;
        end

        // Hold every stage register cleared while reset is asserted.
        if (!reset) begin
            pc_en  = 1'b0;
            pc_sel = PC_SEL_SEQ;
            en_fd  = 1'b0;
            en_de  = 1'b0;
            en_em  = 1'b0;
            en_mw  = 1'b0;
            clr_fd = 1'b1;
            clr_de = 1'b1;
            clr_em = 1'b1;
            clr_mw = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            state_q <= state_next;
            if (state_next == ST_STALL) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, compared against
// a cycle-level reference model through an expected-value queue.
module tb_pipe_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
    localparam int EW       = 46;

    localparam logic [1:0] M_RUN   = 2'b00;
    localparam logic [1:0] M_STALL = 2'b01;
    localparam logic [1:0] M_FLUSH = 2'b10;

    logic        clk;
    logic        reset;
    logic        d_stall_req;
    logic        md_start;
    logic        md_is_div;
    logic        md_use_d;
    logic        exc_req;
    logic        eret_req;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        en_fd, en_de, en_em, en_mw;
    logic        clr_fd, clr_de, clr_em, clr_mw;
    logic        md_busy;
    logic [1:0]  state;
    logic [31:0] stall_cnt;

    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_errors;
    int            cycle_no;

    // Reference model state
    logic [1:0]  m_state;
    int          m_md_left;
    logic [31:0] m_stalls;

    pipe_ctrl #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .d_stall_req (d_stall_req),
        .md_start    (md_start),
        .md_is_div   (md_is_div),
        .md_use_d    (md_use_d),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .en_fd       (en_fd),
        .en_de       (en_de),
        .en_em       (en_em),
        .en_mw       (en_mw),
        .clr_fd      (clr_fd),
        .clr_de      (clr_de),
        .clr_em      (clr_em),
        .clr_mw      (clr_mw),
        .md_busy     (md_busy),
        .state       (state),
        .stall_cnt   (stall_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got time %0t, required < 200000", $time);
        $fatal(1, "timeout");
    end

    function automatic logic [EW-1:0] pack_out(input logic p_en, input logic [1:0] p_sel,
                                               input logic [3:0] en, input logic [3:0] clr,
                                               input logic busy, input logic [1:0] st,
                                               input logic [31:0] sc);
        return {p_en, p_sel, en, clr, busy, st, sc};
    endfunction

    // Drive one cycle of inputs; model the expected outputs and the next state.
    task automatic drive(input bit rst, input bit ds, input bit ms, input bit mdiv,
                         input bit mud, input bit exc, input bit eret);
        logic       p_en;
        logic [1:0] p_sel;
        logic [3:0] en;
        logic [3:0] clr;
        logic [1:0] nxt;
        bit         busy;
        bit         stall;
        @(posedge clk);
        #1;
        reset       = rst;
        d_stall_req = ds;
        md_start    = ms;
        md_is_div   = mdiv;
        md_use_d    = mud;
        exc_req     = exc;
        eret_req    = eret;
        cycle_no++;
        if (!rst) begin
            m_state   = M_RUN;
            m_md_left = 0;
            m_stalls  = 32'd0;
            exp_q.push_back(pack_out(1'b0, 2'b00, 4'b0000, 4'b1111, 1'b0, M_RUN, 32'd0));
        end else begin
            busy  = (m_md_left > 0);
            stall = (m_state != M_FLUSH) && (ds || (mud && (busy || ms)));
            if (exc) begin
                p_en = 1; p_sel = 2'b01; en = 4'b1111; clr = 4'b1111; nxt = M_FLUSH;
            end else if (eret) begin
                p_en = 1; p_sel = 2'b10; en = 4'b1111; clr = 4'b1110; nxt = M_FLUSH;
            end else if (stall) begin
                p_en = 0; p_sel = 2'b00; en = 4'b0111; clr = 4'b0100; nxt = M_STALL;
            end else begin
                p_en = 1; p_sel = 2'b00; en = 4'b1111; clr = 4'b0000; nxt = M_RUN;
            end
            exp_q.push_back(pack_out(p_en, p_sel, en, clr, busy, m_state, m_stalls));
            if (ms && !exc && !eret) m_md_left = mdiv ? DIV_CYC : MULT_CYC;
            else if (m_md_left > 0) m_md_left = m_md_left - 1;
            m_state = nxt;
            if (nxt == M_STALL && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cycle_no, act, expv);
        end
    endtask

    // Monitor: sample settled outputs mid-cycle and compare with the queue head
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_en",     {31'd0, pc_en},                   {31'd0, e[45]});
                check("pc_sel",    {30'd0, pc_sel},                  {30'd0, e[44:43]});
                check("en",        {28'd0, en_fd, en_de, en_em, en_mw},     {28'd0, e[42:39]});
                check("clr",       {28'd0, clr_fd, clr_de, clr_em, clr_mw}, {28'd0, e[38:35]});
                check("md_busy",   {31'd0, md_busy},                 {31'd0, e[34]});
                check("state",     {30'd0, state},                   {30'd0, e[33:32]});
                check("stall_cnt", stall_cnt,                        e[31:0]);
            end
        end
    end

    // Stimulus
    initial begin
        reset = 0; d_stall_req = 0; md_start = 0; md_is_div = 0;
        md_use_d = 0; exc_req = 0; eret_req = 0;
        n_checks = 0; n_errors = 0; cycle_no = 0;
        m_state = M_RUN; m_md_left = 0; m_stalls = 0;

        // Reset for three cycles, then release
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Two-cycle data hazard
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(2);
        // Divide then dependent HI/LO use held
        drive(1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 0, 1, 0, 0);
        idle(2);
        // Multiply with dependent use
        drive(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 1, 0, 0);
        idle(1);
        // Exception squashing a divide start
        drive(1, 0, 1, 1, 0, 1, 0);
        idle(3);
        // Exception and eret together, then eret alone
        drive(1, 0, 0, 0, 0, 1, 1);
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 1);
        idle(2);
        // Exception preempting a stall while the divider keeps counting
        drive(1, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 0);
        drive(1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 1, 0, 0);
        // Reset mid-stall with stall_cnt at 5
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 19) == 0));
        end
        idle(1);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
